keccak_permutation: RTL

Iterative Keccak-f[1600] permutation engine. It holds one 1600-bit state register and applies ROUNDS_PER_CYCLE instances of keccak_round per clock until 24 rounds are done, supplying the 7-bit compressed round constant to each instance. It sits between the sponge absorb/squeeze logic (upstream and downstream) and the combinational round datapath. It uses valid/ready handshakes on both sides.

---
 rtl/keccak_globals.sv | 45 ++++
 rtl/keccak_round.sv | 38 +++
 rtl/keccak_round_chain.sv | 26 ++
 rtl/keccak_permutation.sv | 85 ++++++++
 4 files changed

// File: rtl/keccak_globals.sv
// Shared Keccak-f[1600] types, round constants and lane helpers.
// State is indexed [y][x][z]; lanes are 64 bits.
package keccak_globals;

   localparam int KECCAK_NUM_ROUNDS = 24;

   typedef logic [63:0]        k_lane;
   typedef k_lane [4:0]        k_plane;
   typedef k_plane [4:0]       k_state;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } kp_fsm_e;

   // Compressed iota constants: bit j lands on lane bit 2^j-1.
   localparam logic [6:0] RC_TABLE [24] = '{
      7'h01, 7'h1A, 7'h5E, 7'h70, 7'h1F, 7'h21, 7'h79, 7'h55,
      7'h0E, 7'h0C, 7'h35, 7'h26, 7'h3F, 7'h4F, 7'h5D, 7'h53,
      7'h52, 7'h48, 7'h16, 7'h66, 7'h79, 7'h58, 7'h21, 7'h74
   };

   // Rho rotation offsets, indexed [x][y].
   localparam int RHO [5][5] = '{
      '{ 0, 36,  3, 41, 18},
      '{ 1, 44, 10, 45,  2},
      '{62,  6, 43, 15, 61},
      '{28, 55, 25, 21, 56},
      '{27, 20, 39,  8, 14}
   };

   function automatic k_lane rotl(input k_lane v, input int n);
      if (n == 0) return v;
      return (v << n) | (v >> (64 - n));
   endfunction

   function automatic k_lane rc_expand(input logic [6:0] rc);
      k_lane v;
      v = '0;
      for (int j = 0; j < 7; j++) v[(1 << j) - 1] = rc[j];
      return v;
   endfunction

endpackage

// File: rtl/keccak_round.sv
// One combinational Keccak-f[1600] round: theta, rho, pi, chi, iota.
module keccak_round
   import keccak_globals::*;
(
   input  k_state     st_i,
   input  logic [6:0] rc_i,
   output k_state     st_o
);

   logic [4:0][63:0] c;
   logic [4:0][63:0] d;
   k_state           th;
   k_state           bp;

   always_comb begin
      c    = '0;
      d    = '0;
      th   = '0;
      bp   = '0;
      st_o = '0;
      for (int x = 0; x < 5; x++)
         c[x] = st_i[0][x] ^ st_i[1][x] ^ st_i[2][x] ^ st_i[3][x] ^ st_i[4][x];
      for (int x = 0; x < 5; x++)
         d[x] = c[(x + 4) % 5] ^ rotl(c[(x + 1) % 5], 1);
      for (int y = 0; y < 5; y++)
         for (int x = 0; x < 5; x++)
            th[y][x] = st_i[y][x] ^ d[x];
      // rho then pi: lane (x,y) rotates and moves to (y, 2x+3y)
      for (int y = 0; y < 5; y++)
         for (int x = 0; x < 5; x++)
            bp[(2 * x + 3 * y) % 5][y] = rotl(th[y][x], RHO[x][y]);
      for (int y = 0; y < 5; y++)
         for (int x = 0; x < 5; x++)
            st_o[y][x] = bp[y][x] ^ (~bp[y][(x + 1) % 5] & bp[y][(x + 2) % 5]);
      st_o[0][0] = st_o[0][0] ^ rc_expand(rc_i);
   end

endmodule

// File: rtl/keccak_round_chain.sv
// ROUNDS_PER_CYCLE chained rounds starting at round index round_i.
module keccak_round_chain
   import keccak_globals::*;
#(
   parameter int ROUNDS_PER_CYCLE = 1
)(
   input  k_state     st_i,
   input  logic [4:0] round_i,
   output k_state     st_o
);

   k_state stage [ROUNDS_PER_CYCLE + 1];

   assign stage[0] = st_i;

   for (genvar k = 0; k < ROUNDS_PER_CYCLE; k++) begin : g_rnd
      keccak_round u_round (
         .st_i (stage[k]),
         .rc_i (RC_TABLE[round_i + 5'(k)]),
         .st_o (stage[k + 1])
      );
   end

   assign st_o = stage[ROUNDS_PER_CYCLE];

endmodule

// File: rtl/keccak_permutation.sv
// Iterative Keccak-f[1600] engine: IDLE accepts a state, RUN applies
// ROUNDS_PER_CYCLE rounds per clock, DONE holds the result until taken.
module keccak_permutation
   import keccak_globals::*;
#(
   parameter int ROUNDS_PER_CYCLE = 1,
   parameter int NUM_ROUNDS       = 24
)(
   input  logic   clk,
   input  logic   rst,
   input  logic   in_valid,
   output logic   in_ready,
   input  k_state state_in,
   output logic   out_valid,
   input  logic   out_ready,
   output k_state state_out,
   output logic   busy
);

   if ((NUM_ROUNDS != KECCAK_NUM_ROUNDS) || (ROUNDS_PER_CYCLE < 1) ||
       (ROUNDS_PER_CYCLE > KECCAK_NUM_ROUNDS) ||
       ((KECCAK_NUM_ROUNDS % ROUNDS_PER_CYCLE) != 0)) begin : g_bad_cfg
      $error("keccak_permutation: ROUNDS_PER_CYCLE must divide 24 and NUM_ROUNDS must be 24");
   end

   localparam logic [4:0] STEP     = 5'(ROUNDS_PER_CYCLE);
   localparam logic [4:0] LAST_IDX = 5'(NUM_ROUNDS - ROUNDS_PER_CYCLE);

   kp_fsm_e    fsm_q, fsm_d;
   logic [4:0] round_cnt_q, round_cnt_d;
   k_state     st_q, st_d;
   k_state     chain_out;

   keccak_round_chain #(.ROUNDS_PER_CYCLE(ROUNDS_PER_CYCLE)) u_chain (
      .st_i    (st_q),
      .round_i (round_cnt_q),
      .st_o    (chain_out)
   );

   always_comb begin
      fsm_d       = fsm_q;
      round_cnt_d = round_cnt_q;
      st_d        = st_q;
      unique case (fsm_q)
         IDLE: begin
            if (in_valid) begin
               st_d        = state_in;
               round_cnt_d = '0;
               fsm_d       = RUN;
            end
         end
         RUN: begin
            st_d = chain_out;
            if (round_cnt_q == LAST_IDX) begin
               round_cnt_d = '0;
               fsm_d       = DONE;
            end else begin
               round_cnt_d = round_cnt_q + STEP;
            end
         end
         DONE: begin
            if (out_ready) fsm_d = IDLE;
         end
         default: fsm_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_q       <= IDLE;
         round_cnt_q <= '0;
         st_q        <= '0;
      end else begin
         fsm_q       <= fsm_d;
         round_cnt_q <= round_cnt_d;
         st_q        <= st_d;
      end
   end

   assign in_ready  = (fsm_q == IDLE);
   assign out_valid = (fsm_q == DONE);
   assign busy      = (fsm_q == RUN);
   assign state_out = st_q;

endmodule
